// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus-cycle controller.
//   state_t        FSM state encoding (IDLE..RELEASE).
//   REGION_NONE    all-ones region index meaning "no region matched";
//                  consumers slice it down to their index width.
//   PROM0..SRAM1   default region base addresses for the 4-region map.
//   DEF_REGION_*   packed default map built from those bases.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    WAIT    = 3'd2,
    ACK     = 3'd3,
    BERR    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  // Wide enough for the largest index field (NUM_REGIONS = 8 -> 4 bits).
  localparam logic [3:0] REGION_NONE = 4'hF;

  // Default map: each region decodes one 1 MB slot of a 24-bit space.
  localparam logic [23:0] PROM0 = 24'h000000;
  localparam logic [23:0] PROM1 = 24'h100000;
  localparam logic [23:0] SRAM0 = 24'h200000;
  localparam logic [23:0] SRAM1 = 24'h300000;

  localparam logic [23:0] SLOT_MASK = 24'hF00000;

  localparam logic [4*24-1:0] DEF_REGION_BASE = {SRAM1, SRAM0, PROM1, PROM0};
  localparam logic [4*24-1:0] DEF_REGION_MASK = {4{SLOT_MASK}};
  localparam logic [4*4-1:0]  DEF_REGION_WAIT = {4'd2, 4'd3, 4'd0, 4'd0};
  // PROMs are read-only; SRAMs are read/write.
  localparam logic [3:0]      DEF_REGION_RO   = 4'b0011;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous level, plus a
// single-cycle pulse on each rising edge of the synchronised level.
//   clk   system clock
//   rst   synchronous active-high reset (all flops to 0)
//   d     asynchronous input
//   q     synchronised level (2 flops after d)
//   rise  one-cycle pulse when q goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign rise = q & ~prev;

endmodule

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: 68000-style asynchronous bus-cycle controller.
// Synchronises AS/STEP, decodes the address into one-hot chip selects,
// inserts per-region wait states, then answers with DTACK or BERR.
//   MCLK_IN        system clock
//   RESET_IN       synchronous active-high reset
//   AS_IN          address strobe (async)
//   WR_IN          1 = write cycle
//   UDS_IN/LDS_IN  data strobes
//   ADDR_IN        CPU address
//   STEPEN_IN      single-step mode enable (level)
//   STEP_IN        step request (async, rising edge counts)
//   CS             one-hot chip selects
//   OUTPUT_ENABLE  read-data enable to memories
//   DATA_ACK       DTACK
//   BUS_ERROR      BERR
//   REGION_INDEX   matched region, all-ones = none
//   BUSY           FSM not in IDLE
// All outputs are registered.
module bus_cycle_controller
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 24,
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT = DEF_REGION_WAIT,
  parameter logic [NUM_REGIONS-1:0]            REGION_RO   = DEF_REGION_RO,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic                             MCLK_IN,
  input  logic                             RESET_IN,
  input  logic                             AS_IN,
  input  logic                             WR_IN,
  input  logic                             UDS_IN,
  input  logic                             LDS_IN,
  input  logic [ADDR_WIDTH-1:0]            ADDR_IN,
  input  logic                             STEPEN_IN,
  input  logic                             STEP_IN,
  output logic [NUM_REGIONS-1:0]           CS,
  output logic                             OUTPUT_ENABLE,
  output logic                             DATA_ACK,
  output logic                             BUS_ERROR,
  output logic [$clog2(NUM_REGIONS):0]     REGION_INDEX,
  output logic                             BUSY
);

  localparam int IDX_W = $clog2(NUM_REGIONS) + 1;
  localparam int WD_W  = $clog2(BERR_TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(BERR_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_NONE = REGION_NONE[IDX_W-1:0];

  // Synchronisers
  logic as_s, as_rise;
  logic step_s, step_rise;
  logic unused_sync;

  sync_edge u_as_sync (
    .clk (MCLK_IN), .rst (RESET_IN), .d (AS_IN),   .q (as_s),   .rise (as_rise)
  );
  sync_edge u_step_sync (
    .clk (MCLK_IN), .rst (RESET_IN), .d (STEP_IN), .q (step_s), .rise (step_rise)
  );

  // The FSM uses the AS level and only the STEP edge.
  assign unused_sync = as_rise ^ step_s;

  // Address decode: scan high to low so the lowest matching index wins.
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [3:0]       hit_wait;
  logic             hit_ro;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = IDX_NONE;
    hit_wait = '0;
    hit_ro   = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((ADDR_IN & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(i);
        hit_wait = REGION_WAIT[i*4 +: 4];
        hit_ro   = REGION_RO[i];
      end
    end
  end

  // FSM with registered outputs
  state_t          state;
  logic [3:0]      wait_cnt;
  logic [WD_W-1:0] wd;
  logic            wd_hold;

  // Watchdog stands still once DTACK is given, and during a step hold.
  assign wd_hold = (state == ACK) && (DATA_ACK || STEPEN_IN);

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state         <= IDLE;
      CS            <= '0;
      OUTPUT_ENABLE <= 1'b0;
      DATA_ACK      <= 1'b0;
      BUS_ERROR     <= 1'b0;
      BUSY          <= 1'b0;
      REGION_INDEX  <= IDX_NONE;
      wait_cnt      <= '0;
      wd            <= '0;
    end else begin
      BUSY <= 1'b1;

      if (state == IDLE)
        wd <= '0;
      else if (!wd_hold && wd != WD_LAST)
        wd <= wd + 1'b1;

      case (state)
        IDLE: begin
          if (as_s) state <= DECODE;
          else      BUSY  <= 1'b0;
        end

        DECODE: begin
          REGION_INDEX <= hit_idx;
          wait_cnt     <= hit_wait;
          if (!as_s) begin
            state        <= RELEASE;
            REGION_INDEX <= IDX_NONE;
          end else if (wd == WD_LAST || !hit || (WR_IN && hit_ro)) begin
            state     <= BERR;
            BUS_ERROR <= 1'b1;
          end else begin
            CS            <= NUM_REGIONS'(1) << hit_idx;
            OUTPUT_ENABLE <= ~WR_IN & (UDS_IN | LDS_IN);
            if (hit_wait == '0) begin
              state    <= ACK;
              DATA_ACK <= ~STEPEN_IN;
            end else begin
              state <= WAIT;
            end
          end
        end

        // Leaving on count 1 means a wait of N delays DTACK by exactly N
        // cycles relative to the zero-wait case.
        WAIT: begin
          if (!as_s) begin
            state         <= RELEASE;
            CS            <= '0;
            OUTPUT_ENABLE <= 1'b0;
            REGION_INDEX  <= IDX_NONE;
          end else if (wd == WD_LAST) begin
            state         <= BERR;
            CS            <= '0;
            OUTPUT_ENABLE <= 1'b0;
            BUS_ERROR     <= 1'b1;
          end else if (wait_cnt == 4'd1) begin
            state    <= ACK;
            wait_cnt <= '0;
            DATA_ACK <= ~STEPEN_IN;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        // Only step edges seen while already in ACK release the hold.
        ACK: begin
          if (!as_s) begin
            state         <= RELEASE;
            CS            <= '0;
            OUTPUT_ENABLE <= 1'b0;
            DATA_ACK      <= 1'b0;
            REGION_INDEX  <= IDX_NONE;
          end else if (!DATA_ACK && (!STEPEN_IN || step_rise)) begin
            DATA_ACK <= 1'b1;
          end
        end

        BERR: begin
          if (!as_s) begin
            state        <= RELEASE;
            BUS_ERROR    <= 1'b0;
            REGION_INDEX <= IDX_NONE;
          end
        end

        RELEASE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          CS            <= '0;
          OUTPUT_ENABLE <= 1'b0;
          DATA_ACK      <= 1'b0;
          BUS_ERROR     <= 1'b0;
          REGION_INDEX  <= IDX_NONE;
          BUSY          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed bench for bus_cycle_controller. Instance a uses the default
// map; instance b shares the inputs but has region 3 at 15 wait states
// and a 16-cycle bus-error timeout.
module tb_bus_cycle_controller;
  import bus_pkg::*;

  logic        MCLK_IN = 1'b0;
  logic        RESET_IN, AS_IN, WR_IN, UDS_IN, LDS_IN, STEPEN_IN, STEP_IN;
  logic [23:0] ADDR_IN;

  logic [3:0] cs_a, cs_b;
  logic       oe_a, oe_b, dack_a, dack_b, berr_a, berr_b, busy_a, busy_b;
  logic [2:0] ri_a, ri_b;

  int checks = 0;
  int errors = 0;

  always #5 MCLK_IN = ~MCLK_IN;

  bus_cycle_controller dut_a (
    .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN), .AS_IN(AS_IN), .WR_IN(WR_IN),
    .UDS_IN(UDS_IN), .LDS_IN(LDS_IN), .ADDR_IN(ADDR_IN), .STEPEN_IN(STEPEN_IN),
    .STEP_IN(STEP_IN), .CS(cs_a), .OUTPUT_ENABLE(oe_a), .DATA_ACK(dack_a),
    .BUS_ERROR(berr_a), .REGION_INDEX(ri_a), .BUSY(busy_a)
  );

  bus_cycle_controller #(
    .REGION_WAIT ({4'd15, 4'd3, 4'd0, 4'd0}),
    .BERR_TIMEOUT(16)
  ) dut_b (
    .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN), .AS_IN(AS_IN), .WR_IN(WR_IN),
    .UDS_IN(UDS_IN), .LDS_IN(LDS_IN), .ADDR_IN(ADDR_IN), .STEPEN_IN(STEPEN_IN),
    .STEP_IN(STEP_IN), .CS(cs_b), .OUTPUT_ENABLE(oe_b), .DATA_ACK(dack_b),
    .BUS_ERROR(berr_b), .REGION_INDEX(ri_b), .BUSY(busy_b)
  );

  // Advance n rising edges and settle 1 time unit after the last.
  task automatic tick(input int n);
    repeat (n) @(posedge MCLK_IN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET_IN = 1'b1; AS_IN = 1'b0; WR_IN = 1'b0; UDS_IN = 1'b0; LDS_IN = 1'b0;
    STEPEN_IN = 1'b0; STEP_IN = 1'b0; ADDR_IN = '0;
    tick(3);

    // Reset state
    chk("rst_cs",   cs_a,   0);
    chk("rst_oe",   oe_a,   0);
    chk("rst_dack", dack_a, 0);
    chk("rst_berr", berr_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ri",   ri_a,   3'h7);
    RESET_IN = 1'b0;
    tick(2);

    // 1: zero-wait read of PROM0
    ADDR_IN = PROM0 | 24'h000100; WR_IN = 1'b0; UDS_IN = 1'b1; LDS_IN = 1'b1;
    AS_IN = 1'b1;
    tick(3);
    chk("t1_dack_e3", dack_a, 0);
    chk("t1_busy_e3", busy_a, 1);
    tick(1);
    chk("t1_dack_e4", dack_a, 1);
    chk("t1_cs",      cs_a,   4'b0001);
    chk("t1_oe",      oe_a,   1);
    chk("t1_ri",      ri_a,   0);
    chk("t1_berr",    berr_a, 0);
    AS_IN = 1'b0;
    tick(3);
    chk("t1_rel_cs",   cs_a,   0);
    chk("t1_rel_oe",   oe_a,   0);
    chk("t1_rel_dack", dack_a, 0);
    chk("t1_rel_ri",   ri_a,   3'h7);
    tick(1);
    chk("t1_idle", busy_a, 0);

    // 2: write to SRAM0 with 3 wait states
    ADDR_IN = SRAM0 | 24'h000010; WR_IN = 1'b1;
    AS_IN = 1'b1;
    tick(6);
    chk("t2_dack_e6", dack_a, 0);
    chk("t2_cs",      cs_a,   4'b0100);
    chk("t2_oe",      oe_a,   0);
    tick(1);
    chk("t2_dack_e7", dack_a, 1);
    chk("t2_ri",      ri_a,   2);
    AS_IN = 1'b0;
    tick(4);
    chk("t2_idle", busy_a, 0);

    // 3: unmapped address
    ADDR_IN = 24'hF00000; WR_IN = 1'b0;
    AS_IN = 1'b1;
    tick(3);
    chk("t3_berr_e3", berr_a, 0);
    tick(1);
    chk("t3_berr_e4", berr_a, 1);
    chk("t3_cs",      cs_a,   0);
    chk("t3_dack",    dack_a, 0);
    chk("t3_ri",      ri_a,   3'h7);
    tick(10);
    chk("t3_berr_hold", berr_a, 1);
    AS_IN = 1'b0;
    tick(3);
    chk("t3_berr_rel", berr_a, 0);
    tick(1);
    chk("t3_idle", busy_a, 0);

    // 4: single-step hold well past the timeout on both instances
    STEPEN_IN = 1'b1;
    ADDR_IN = PROM1 | 24'h000004; WR_IN = 1'b0;
    AS_IN = 1'b1;
    tick(4);
    chk("t4_dack_hold", dack_a, 0);
    chk("t4_cs",        cs_a,   4'b0010);
    tick(200);
    chk("t4_no_berr_a", berr_a, 0);
    chk("t4_no_berr_b", berr_b, 0);
    chk("t4_dack_wait", dack_a, 0);
    STEP_IN = 1'b1;
    tick(2);
    chk("t4_dack_s2", dack_a, 0);
    tick(1);
    chk("t4_dack_s3_a", dack_a, 1);
    chk("t4_dack_s3_b", dack_b, 1);
    chk("t4_berr_s3",   berr_a, 0);
    STEP_IN = 1'b0; STEPEN_IN = 1'b0; AS_IN = 1'b0;
    tick(4);
    chk("t4_idle", busy_a, 0);

    // 5: 15 wait states against a 16-cycle timeout (instance b)
    ADDR_IN = SRAM1; WR_IN = 1'b0;
    AS_IN = 1'b1;
    tick(6);
    chk("t5_dack_a_e6", dack_a, 1);
    chk("t5_dack_b_e6", dack_b, 0);
    chk("t5_oe_b",      oe_b,   1);
    chk("t5_ri_b",      ri_b,   3);
    tick(12);
    chk("t5_berr_b_e18", berr_b, 0);
    chk("t5_cs_b_e18",   cs_b,   4'b1000);
    tick(1);
    chk("t5_berr_b_e19", berr_b, 1);
    chk("t5_dack_b_e19", dack_b, 0);
    chk("t5_cs_b_e19",   cs_b,   0);
    tick(5);
    chk("t5_dack_b_late", dack_b, 0);
    AS_IN = 1'b0;
    tick(4);
    chk("t5_idle_a", busy_a, 0);
    chk("t5_idle_b", busy_b, 0);

    // Aborted cycle: AS drops during WAIT, no DTACK/BERR pulse
    ADDR_IN = SRAM0; WR_IN = 1'b0;
    AS_IN = 1'b1;
    tick(4);
    AS_IN = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("ab_no_pulse", {30'd0, dack_a, berr_a}, 0);
    end
    chk("ab_idle", busy_a, 0);

    // 6a: reset in the middle of WAIT
    ADDR_IN = SRAM0; WR_IN = 1'b1;
    AS_IN = 1'b1;
    tick(5);
    chk("t6_cs_wait", cs_a, 4'b0100);
    RESET_IN = 1'b1;
    tick(1);
    chk("t6_rst_cs",   cs_a,   0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_ri",   ri_a,   3'h7);
    chk("t6_rst_dack", dack_a, 0);
    RESET_IN = 1'b0; AS_IN = 1'b0;
    tick(3);
    chk("t6_post_busy", busy_a, 0);

    // 6b: write to read-only PROM0
    ADDR_IN = PROM0 | 24'h000010; WR_IN = 1'b1;
    AS_IN = 1'b1;
    tick(4);
    chk("t6_ro_berr", berr_a, 1);
    chk("t6_ro_cs",   cs_a,   0);
    chk("t6_ro_dack", dack_a, 0);
    chk("t6_ro_ri",   ri_a,   0);
    AS_IN = 1'b0;
    tick(4);
    chk("t6_ro_berr_rel", berr_a, 0);
    chk("t6_ro_idle",     busy_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
